// File: rtl/rr_mutex_arbiter_if.sv
// Request/grant bundle between NREQ requesters and the round-robin mutex arbiter.
// The master side owns req; the slave (arbiter) side owns the grant and status signals.
interface rr_mutex_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            busy;
    logic            err;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  err
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output busy,
        output err
    );
endinterface

// File: rtl/rr_mutex_arbiter.sv
// N-way round-robin mutex: one registered one-hot grant at a time, a GAP-cycle
// guard between tenures, and a sticky flag for one-cycle req glitches by the holder.
module rr_mutex_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int GAP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    rr_mutex_arbiter_if.slave arb
);

    if (NREQ < 2 || NREQ > 16 || (1 << IDW) < NREQ || GAP < 0 || GAP > 7) begin : g_bad_param
        $error("rr_mutex_arbiter: illegal NREQ/IDW/GAP combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [2:0]     gap_cnt;
    logic           rel_chk;
    logic [IDW-1:0] sel;

    // First set request at or after base, wrapping modulo NREQ; lower offsets win.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  base);
        logic [IDW-1:0] pick;
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (r[(int'(base) + k) % NREQ]) begin
                pick = IDW'((int'(base) + k) % NREQ);
            end
        end
        return pick;
    endfunction

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return IDW'((int'(i) + 1) % NREQ);
    endfunction

    assign sel = rr_pick(arb.req, ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gap_cnt    <= '0;
            rel_chk    <= 1'b0;
            arb.gnt    <= '0;
            arb.gnt_id <= '0;
            arb.busy   <= 1'b0;
            arb.err    <= 1'b0;
        end else begin
            // gnt_id still names the just-released holder on the cycle after release.
            rel_chk <= 1'b0;
            if (rel_chk && arb.req[arb.gnt_id]) begin
                arb.err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (|arb.req) begin
                        arb.gnt    <= NREQ'(1) << sel;
                        arb.gnt_id <= sel;
                        arb.busy   <= 1'b1;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (!arb.req[arb.gnt_id]) begin
                        arb.gnt <= '0;
                        ptr     <= next_idx(arb.gnt_id);
                        rel_chk <= 1'b1;
                        if (GAP == 0) begin
                            arb.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            gap_cnt <= 3'(GAP);
                            state   <= GUARD;
                        end
                    end
                end
                GUARD: begin
                    if (gap_cnt <= 3'd1) begin
                        gap_cnt  <= '0;
                        arb.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mutex_arbiter.sv
// Self-checking bench for rr_mutex_arbiter (NREQ=4, IDW=2, GAP=1): vector table,
// hand-written corner sequences and random traffic against a behavioural model.
module tb_rr_mutex_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int GAP  = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rr_mutex_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    rr_mutex_arbiter #(.NREQ(NREQ), .IDW(IDW), .GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: who holds, how much guard time remains, rotation pointer.
    int m_holder;
    int m_gap;
    int m_ptr;
    int m_last;
    int m_rel;
    bit m_err;
    logic [NREQ-1:0] prev_gnt;

    typedef struct {
        bit       rst_before;
        logic [3:0] req;
        logic [3:0] gnt;
        bit       busy;
        int       id;
        bit       err;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit rb, logic [3:0] r, logic [3:0] g, bit b, int id, bit e);
        vec_t v;
        v.rst_before = rb;
        v.req = r;
        v.gnt = g;
        v.busy = b;
        v.id = id;
        v.err = e;
        tbl.push_back(v);
    endfunction

    function automatic void model_reset();
        m_holder = -1;
        m_gap = 0;
        m_ptr = 0;
        m_last = 0;
        m_rel = -1;
        m_err = 1'b0;
    endfunction

    function automatic void model_step(logic [NREQ-1:0] r);
        if (m_rel >= 0 && r[m_rel]) m_err = 1'b1;
        m_rel = -1;
        if (m_holder >= 0) begin
            if (!r[m_holder]) begin
                m_rel = m_holder;
                m_ptr = (m_holder + 1) % NREQ;
                m_holder = -1;
                m_gap = GAP;
            end
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (r[i]) begin
                    m_holder = i;
                    m_last = i;
                    break;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NREQ-1:0] eg;
        eg = (m_holder >= 0) ? NREQ'(1 << m_holder) : '0;
        chk({tag, " gnt"}, int'(bus.gnt), int'(eg));
        chk({tag, " busy"}, int'(bus.busy), int'(m_holder >= 0 || m_gap > 0));
        chk({tag, " gnt_id"}, int'(bus.gnt_id), m_last);
        chk({tag, " err"}, int'(bus.err), int'(m_err));
        chk({tag, " onehot"}, int'($countones(bus.gnt) <= 1), 1);
        if (prev_gnt != '0 && bus.gnt != '0) chk({tag, " handover"}, int'(bus.gnt), int'(prev_gnt));
        prev_gnt = bus.gnt;
    endtask

    task automatic cycle(input logic [NREQ-1:0] r, input string tag);
        bus.req = r;
        @(posedge clk);
        model_step(r);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        model_reset();
        prev_gnt = '0;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] po;
        int hc[NREQ];
        int lc[NREQ];
        int order[$];

        bus.req = '0;
        model_reset();
        prev_gnt = '0;

        // single requester, request arriving during the guard gap
        add(1, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 4'b0001, 1, 0, 0);
        add(0, 4'b0001, 4'b0001, 1, 0, 0);
        add(0, 4'b0000, 4'b0000, 1, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 4'b0100, 1, 2, 0);
        add(0, 4'b0000, 4'b0000, 1, 2, 0);
        add(0, 4'b1000, 4'b0000, 0, 2, 0);
        add(0, 4'b1000, 4'b1000, 1, 3, 0);
        add(0, 4'b1000, 4'b1000, 1, 3, 0);
        add(0, 4'b0000, 4'b0000, 1, 3, 0);
        add(0, 4'b0000, 4'b0000, 0, 3, 0);
        // simultaneous request from reset
        add(1, 4'b0011, 4'b0001, 1, 0, 0);
        add(0, 4'b0011, 4'b0001, 1, 0, 0);
        add(0, 4'b0010, 4'b0000, 1, 0, 0);
        add(0, 4'b0010, 4'b0000, 0, 0, 0);
        add(0, 4'b0010, 4'b0010, 1, 1, 0);
        add(0, 4'b0000, 4'b0000, 1, 1, 0);
        add(0, 4'b0000, 4'b0000, 0, 1, 0);
        // glitch by holder 2: err sticks, arbitration continues
        add(1, 4'b0100, 4'b0100, 1, 2, 0);
        add(0, 4'b0100, 4'b0100, 1, 2, 0);
        add(0, 4'b0000, 4'b0000, 1, 2, 0);
        add(0, 4'b0100, 4'b0000, 0, 2, 1);
        add(0, 4'b0100, 4'b0100, 1, 2, 1);
        add(0, 4'b0000, 4'b0000, 1, 2, 1);
        add(0, 4'b0000, 4'b0000, 0, 2, 1);

        #2;
        do_reset();
        for (int i = 0; i < 10; i++) cycle('0, "idle");

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            cycle(tbl[i].req, $sformatf("tbl%0d model", i));
            chk($sformatf("tbl%0d gnt", i), int'(bus.gnt), int'(tbl[i].gnt));
            chk($sformatf("tbl%0d busy", i), int'(bus.busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d gnt_id", i), int'(bus.gnt_id), tbl[i].id);
            chk($sformatf("tbl%0d err", i), int'(bus.err), int'(tbl[i].err));
        end
        do_reset();
        chk("err cleared by rst", int'(bus.err), 0);

        // round-robin rotation with four-phase requesters
        r = '1;
        po = '0;
        for (int i = 0; i < NREQ; i++) begin
            hc[i] = 0;
            lc[i] = 0;
        end
        for (int c = 0; c < 120 && order.size() < 6; c++) begin
            cycle(r, "rr");
            g = bus.gnt;
            if (g != '0 && po == '0) begin
                for (int i = 0; i < NREQ; i++) if (g[i]) order.push_back(i);
            end
            po = g;
            for (int i = 0; i < NREQ; i++) begin
                if (r[i]) begin
                    if (g[i]) begin
                        hc[i]++;
                        if (hc[i] >= 3) begin
                            r[i] = 1'b0;
                            lc[i] = 0;
                        end
                    end
                end else begin
                    lc[i]++;
                    if (lc[i] >= 2 && !g[i]) begin
                        r[i] = 1'b1;
                        hc[i] = 0;
                    end
                end
            end
        end
        chk("rr grant count", order.size(), 6);
        for (int k = 0; k < order.size() && k < 6; k++) chk($sformatf("rr order%0d", k), order[k], k % NREQ);
        chk("rr no err", int'(bus.err), 0);

        // async reset mid-grant with a non-zero pointer
        do_reset();
        cycle(4'b0100, "pre");
        cycle(4'b0100, "pre");
        cycle(4'b0000, "pre");
        cycle(4'b0000, "pre");
        cycle(4'b0100, "pre");
        cycle(4'b0100, "pre");
        chk("pre_rst gnt", int'(bus.gnt), 4);
        #2;
        rst = 1'b1;
        model_reset();
        prev_gnt = '0;
        #1;
        chk("async_rst gnt", int'(bus.gnt), 0);
        chk("async_rst busy", int'(bus.busy), 0);
        bus.req = 4'b1100;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cycle(4'b1100, "after_rst");
        chk("after_rst gnt", int'(bus.gnt), 4);
        chk("after_rst gnt_id", int'(bus.gnt_id), 2);
        cycle(4'b0000, "after_rst");
        cycle(4'b0000, "after_rst");

        // random traffic; holders tend to keep their request
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 0) do_reset();
            r = NREQ'($urandom_range(0, 15));
            if (bus.gnt != '0 && $urandom_range(0, 3) != 0) r = r | bus.gnt;
            cycle(r, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_mutex_arbiter.md
Name: rr_mutex_arbiter

Overview:
- Synchronous N-way round-robin arbiter providing exclusive access to one shared resource.
- Generalises the two-input mutex grant semantics to NREQ requesters with fair rotation.
- Each requester uses a four-phase req/grant handshake.
- A mandatory guard gap between grants guarantees no two grants are ever asserted together, including across hand-over.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, 2, width of encoded grant index; must satisfy 2**IDW >= NREQ.
- GAP, 1, idle cycles inserted between release of one grant and issue of the next (0..7).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  request vector; req[i] high = requester i wants the resource.
- gnt  output  NREQ  one-hot or zero grant vector, registered.
- gnt_id  output  IDW  index of the current or most recent grantee, registered.
- busy  output  1  high while any grant is held or a guard gap is running.
- err  output  1  sticky; set if a granted requester's req is seen low for exactly one cycle and then high again (glitch). Cleared only by rst.

Behaviour:
- Reset values (async, active-high):
  - gnt=0, gnt_id=0, busy=0, err=0.
  - State=IDLE, priority pointer ptr=0, gap counter=0.
- States:
  - IDLE: no grant held.
    - If any req bit is set, select the first set bit searching from ptr upward, wrapping modulo NREQ.
    - Next cycle: gnt[sel]=1, gnt_id=sel, busy=1, state=GRANT.
    - Latency from req rise to gnt rise is 1 clock when the arbiter is idle and any GAP has expired.
  - GRANT: gnt[sel] held high; req changes on other requesters are ignored.
    - When req[sel] is sampled low, gnt[sel] drops on the next edge and ptr becomes (sel+1) mod NREQ.
    - If GAP=0, go to IDLE. If GAP>0, load the gap counter with GAP and go to GAP.
  - GAP: gnt=0, busy=1, counter decrements each cycle.
    - When the counter reaches 0, state=IDLE and busy drops at the same edge.
    - Requests arriving during GAP are arbitrated on entry to IDLE.
- Four-phase rule:
  - The requester raises req, waits for gnt, uses the resource, drops req, then waits for gnt low before raising req again.
  - A requester that raises req again while its gnt is still high is treated as still holding.
  - Glitch detection: req[sel] low for one sample with gnt still high is the only case that sets err. Because release is acted on at that sample, this manifests as req re-rising the cycle gnt falls; err sets on that cycle.
- Mutual exclusion:
  - popcount(gnt) <= 1 on every cycle.
  - gnt never changes from one nonzero value to another nonzero value on a single edge.
  - When GAP=0 there is still at least one cycle with gnt=0 between different grantees, because IDLE arbitration takes one edge.
- Fairness:
  - With all NREQ requesting continuously and re-requesting immediately after release, grant order is 0,1,2,...,NREQ-1,0,...
  - A continuously requesting requester waits at most NREQ-1 other grant tenures.
- Simultaneous events:
  - Release by the grantee and new requests on the same cycle: release is processed first and arbitration occurs in IDLE afterwards, using the updated ptr.
  - The released requester re-raising immediately gets lowest priority.
- gnt_id holds its last value in IDLE and GAP.
- Reset mid-operation: gnt drops immediately (asynchronously) and ptr returns to 0. No handshake completion is owed to the interrupted requester.
- Out-of-range bits: if NREQ < 2**IDW, gnt_id never exceeds NREQ-1.

Test Plan:
- Reset then idle: rst pulse with req=0 for 10 cycles -> gnt=0, busy=0, err=0, gnt_id=0 throughout.
- Single requester (NREQ=4, GAP=1):
  - req=0001 at cycle 5 -> gnt=0001 at cycle 6, busy=1.
  - req=0000 at cycle 10 -> gnt=0000 at cycle 11, busy=1 at cycle 11, busy=0 at cycle 12.
- Simultaneous request: req=0011 from a reset state -> gnt=0001.
  - Drop req[0] -> after the one-cycle gap, gnt=0010 and gnt_id=1.
  - At no cycle is gnt=0011.
- Round-robin rotation: req=1111, each grantee drops req 3 cycles after its gnt and re-raises 1 cycle later -> grant sequence 0,1,2,3,0,1.
  - gnt_id matches each grant.
  - popcount(gnt) <= 1 on all cycles.
- Glitch detection: holder 2 drops req for one cycle and re-raises the cycle gnt falls -> err=1 and stays 1 until rst.
  - Arbitration continues normally afterwards.
- Async reset mid-grant: gnt=0100, assert rst between clock edges -> gnt=0000 before the next clk edge, busy=0.
  - After rst release with req=1100, the next grant is gnt=0100 (ptr=0 search).
